// File: rtl/switch_allocator.sv
// Wormhole switch allocator: per-output round-robin over head flits, output locked from head to tail.
// Define SA_LOCK_TIMEOUT_EN to force-release outputs whose owner has been idle for LOCK_TIMEOUT cycles.
module switch_allocator #(
  parameter int NPORT        = 5,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NPORT-1:0]     in_valid,
  input  logic [5*NPORT-1:0]   in_route,
  input  logic [3*NPORT-1:0]   in_flit_type,
  input  logic [NPORT-1:0]     out_ready,
  output logic [NPORT-1:0]     in_grant,
  output logic [3*NPORT-1:0]   xbar_sel,
  output logic [NPORT-1:0]     out_valid,
  output logic [2*NPORT-1:0]   out_vc,
  output logic [NPORT-1:0]     out_locked,
  output logic [NPORT-1:0]     lock_timeout
);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;

  localparam logic [2:0] FT_HEAD = 3'b000;
  localparam logic [2:0] FT_TAIL = 3'b010;

  if (NPORT < 2 || NPORT > 7 || LOCK_TIMEOUT < 1) begin : g_param_chk
    $error("switch_allocator: unsupported parameter values");
  end

  lock_state_t      r_state     [NPORT];
  lock_state_t      w_state_nxt [NPORT];
  logic [2:0]       r_owner     [NPORT];
  logic [2:0]       w_owner_nxt [NPORT];
  logic [2:0]       r_rr        [NPORT];
  logic [2:0]       w_rr_nxt    [NPORT];
  logic [2:0]       w_port      [NPORT];
  logic [2:0]       w_type      [NPORT];
  logic [1:0]       w_vc        [NPORT];
  logic [2:0]       w_win       [NPORT];
  logic [NPORT-1:0] w_elig;
  logic [NPORT-1:0] w_out_gnt;

`ifdef SA_LOCK_TIMEOUT_EN
  localparam int unsigned CW = $clog2(LOCK_TIMEOUT + 1);
  logic [CW-1:0]    r_idle [NPORT];
  logic [NPORT-1:0] r_timeout;
  logic [NPORT-1:0] w_expire;
`endif

  always_comb begin
    for (int unsigned i = 0; i < NPORT; i++) begin
      w_port[i] = in_route[5*i+2 +: 3];
      w_vc[i]   = in_route[5*i +: 2];
      w_type[i] = in_flit_type[3*i +: 3];
      w_elig[i] = in_valid[i] && (w_port[i] < 3'(NPORT)) && (w_type[i] <= FT_TAIL);
    end
  end

  // Arbitration, next state and crossbar outputs; grants are suppressed while reset is held.
  always_comb begin
    int unsigned idx;
    logic [2:0]  cand;
    idx       = 0;
    cand      = '0;
    w_out_gnt = '0;
    in_grant  = '0;
    out_valid = '0;
    xbar_sel  = '1;
    out_vc    = '0;
`ifdef SA_LOCK_TIMEOUT_EN
    w_expire  = '0;
`endif
    for (int unsigned o = 0; o < NPORT; o++) begin
      w_win[o]       = '0;
      w_state_nxt[o] = r_state[o];
      w_owner_nxt[o] = r_owner[o];
      w_rr_nxt[o]    = r_rr[o];
      out_locked[o]  = (r_state[o] == LOCKED);

      if (rst && out_ready[o]) begin
        if (r_state[o] == UNLOCKED) begin
          for (int unsigned k = 0; k < NPORT; k++) begin
            idx = 32'(r_rr[o]) + k;
            if (idx >= NPORT) idx = idx - NPORT;
            cand = 3'(idx);
            if (!w_out_gnt[o] && w_elig[cand] && w_port[cand] == 3'(o) && w_type[cand] == FT_HEAD) begin
              w_out_gnt[o] = 1'b1;
              w_win[o]     = cand;
            end
          end
        end else if (w_elig[r_owner[o]] && w_port[r_owner[o]] == 3'(o)) begin
          w_out_gnt[o] = 1'b1;
          w_win[o]     = r_owner[o];
        end
      end

      if (w_out_gnt[o]) begin
        in_grant[w_win[o]]  = 1'b1;
        out_valid[o]        = 1'b1;
        xbar_sel[3*o +: 3]  = w_win[o];
        out_vc[2*o +: 2]    = w_vc[w_win[o]];
        if (r_state[o] == UNLOCKED) begin
          w_state_nxt[o] = LOCKED;
          w_owner_nxt[o] = w_win[o];
          w_rr_nxt[o]    = (w_win[o] == 3'(NPORT-1)) ? '0 : w_win[o] + 3'd1;
        end else if (w_type[w_win[o]] == FT_TAIL) begin
          w_state_nxt[o] = UNLOCKED;
          w_owner_nxt[o] = '0;
        end
      end
`ifdef SA_LOCK_TIMEOUT_EN
      else if (r_state[o] == LOCKED && r_idle[o] == CW'(LOCK_TIMEOUT - 1)) begin
        w_expire[o]    = 1'b1;
        w_state_nxt[o] = UNLOCKED;
        w_owner_nxt[o] = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned o = 0; o < NPORT; o++) begin
      if (!rst) begin
        r_state[o] <= UNLOCKED;
        r_owner[o] <= '0;
        r_rr[o]    <= '0;
      end else begin
        r_state[o] <= w_state_nxt[o];
        r_owner[o] <= w_owner_nxt[o];
        r_rr[o]    <= w_rr_nxt[o];
      end
    end
  end

`ifdef SA_LOCK_TIMEOUT_EN
  always_ff @(posedge clk) begin
    for (int unsigned o = 0; o < NPORT; o++) begin
      if (!rst) begin
        r_idle[o]    <= '0;
        r_timeout[o] <= 1'b0;
      end else begin
        r_timeout[o] <= w_expire[o];
        if (w_out_gnt[o] || r_state[o] == UNLOCKED || w_expire[o]) r_idle[o] <= '0;
        else                                                        r_idle[o] <= r_idle[o] + 1'b1;
      end
    end
  end

  assign lock_timeout = r_timeout;
`else
  assign lock_timeout = '0;
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: flit queues per input, an integer-level allocation model
// checked every cycle, and hand-computed grant sequences for each scenario.
module tb_switch_allocator;
  localparam int NP = 5;
  localparam int LT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  in_valid, out_ready, in_grant, out_valid, out_locked, lock_timeout;
  logic [24:0] in_route;
  logic [14:0] in_flit_type, xbar_sel;
  logic [9:0]  out_vc;

  always #5 clk = ~clk;

  switch_allocator #(.NPORT(NP), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_route(in_route),
    .in_flit_type(in_flit_type), .out_ready(out_ready), .in_grant(in_grant),
    .xbar_sel(xbar_sel), .out_valid(out_valid), .out_vc(out_vc),
    .out_locked(out_locked), .lock_timeout(lock_timeout)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [2:0] port;
    logic [1:0] vc;
    logic [2:0] ft;
  } flit_t;

  flit_t q [NP][$];

  // ---------------- reference model (integer owner, -1 = free) ----------------
  int m_owner [NP];
  int m_rr    [NP];
  int m_idle  [NP];
  int m_to    [NP];
  int nx_owner[NP];
  int nx_rr   [NP];
  int nx_idle [NP];
  int nx_to   [NP];
  bit m_on = 1'b0;

  function automatic bit wants(input int i, input int o);
    int p, t;
    p = int'(in_route[5*i+2 +: 3]);
    t = int'(in_flit_type[3*i +: 3]);
    return in_valid[i] && p == o && t <= 2;
  endfunction

  always @(negedge clk) begin
    logic [4:0]  e_g, e_v, e_lk, e_to;
    logic [14:0] e_sel;
    logic [9:0]  e_vc;
    int win, i;
    if (m_on) begin
      e_g = '0; e_v = '0; e_lk = '0; e_to = '0; e_sel = '1; e_vc = '0;
      for (int o = 0; o < NP; o++) begin
        nx_owner[o] = m_owner[o]; nx_rr[o] = m_rr[o]; nx_idle[o] = m_idle[o]; nx_to[o] = 0;
        e_lk[o] = (m_owner[o] >= 0);
        e_to[o] = (m_to[o] != 0);
        win = -1;
        if (rst && out_ready[o]) begin
          if (m_owner[o] < 0) begin
            for (int k = 0; k < NP; k++) begin
              i = (m_rr[o] + k) % NP;
              if (win < 0 && wants(i, o) && in_flit_type[3*i +: 3] == 3'b000) win = i;
            end
          end else if (wants(m_owner[o], o)) begin
            win = m_owner[o];
          end
        end
        if (win >= 0) begin
          e_g[win] = 1'b1;
          e_v[o] = 1'b1;
          e_sel[3*o +: 3] = 3'(win);
          e_vc[2*o +: 2] = in_route[5*win +: 2];
          nx_idle[o] = 0;
          if (m_owner[o] < 0) begin
            nx_owner[o] = win;
            nx_rr[o] = (win + 1) % NP;
          end else if (in_flit_type[3*win +: 3] == 3'b010) begin
            nx_owner[o] = -1;
          end
        end else if (m_owner[o] >= 0) begin
`ifdef SA_LOCK_TIMEOUT_EN
          nx_idle[o] = m_idle[o] + 1;
          if (nx_idle[o] == LT) begin
            nx_owner[o] = -1; nx_idle[o] = 0; nx_to[o] = 1;
          end
`endif
        end
      end
      n_vec++;
      if ({in_grant, xbar_sel, out_valid, out_vc, out_locked, lock_timeout} !==
          {e_g, e_sel, e_v, e_vc, e_lk, e_to}) begin
        n_err++;
        $display("FAIL model t=%0t act g=%b sel=%h v=%b vc=%h lk=%b to=%b exp g=%b sel=%h v=%b vc=%h lk=%b to=%b",
                 $time, in_grant, xbar_sel, out_valid, out_vc, out_locked, lock_timeout,
                 e_g, e_sel, e_v, e_vc, e_lk, e_to);
      end
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      m_on <= 1'b1;
      for (int o = 0; o < NP; o++) begin
        m_owner[o] <= -1; m_rr[o] <= 0; m_idle[o] <= 0; m_to[o] <= 0;
      end
    end else if (m_on) begin
      for (int o = 0; o < NP; o++) begin
        m_owner[o] <= nx_owner[o]; m_rr[o] <= nx_rr[o]; m_idle[o] <= nx_idle[o]; m_to[o] <= nx_to[o];
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      if (q[i].size() > 0) begin
        in_valid[i] = 1'b1;
        in_route[5*i +: 5] = {q[i][0].port, q[i][0].vc};
        in_flit_type[3*i +: 3] = q[i][0].ft;
      end else begin
        in_valid[i] = 1'b0;
        in_route[5*i +: 5] = '0;
        in_flit_type[3*i +: 3] = '0;
      end
    end
  endtask

  task automatic push(input int i, input int port, input int vc, input int ft);
    flit_t f;
    f.port = 3'(port); f.vc = 2'(vc); f.ft = 3'(ft);
    q[i].push_back(f);
  endtask

  // Called at the negedge: pops whatever was granted, then drives the next flits.
  task automatic finish_cycle();
    logic [4:0] g;
    g = in_grant;
    @(posedge clk);
    for (int i = 0; i < NP; i++)
      if (g[i] && q[i].size() > 0) void'(q[i].pop_front());
    #1 drive();
  endtask

  task automatic run_expect(input string tag, input int o, input int exp[$], input int vc);
    foreach (exp[k]) begin
      @(negedge clk);
      chk($sformatf("%s_sel%0d", tag, k), 32'(xbar_sel[3*o +: 3]), 32'(exp[k]));
      if (exp[k] != 7) chk($sformatf("%s_vc%0d", tag, k), 32'(out_vc[2*o +: 2]), 32'(vc));
      finish_cycle();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    out_ready = '1;
    in_valid = '0; in_route = '0; in_flit_type = '0;
    for (int i = 0; i < NP; i++) push(i, (i + 1) % NP, 0, 0);
    drive();
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    chk("rst_grant", 32'(in_grant), 32'h0);
    chk("rst_sel", 32'(xbar_sel), 32'h7FFF);
    chk("rst_locked", 32'(out_locked), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < NP; i++) q[i].delete();
    drive();

    // Contention at East: rr from 0 gives 0, then 2, then 4.
    for (int i = 0; i <= 4; i += 2) begin push(i, 1, 1, 0); push(i, 1, 1, 2); end
    drive();
    run_expect("cont", 1, '{0, 0, 2, 2, 4, 4, 7}, 1);
    // rr[1] back at 0: input 1 beats input 3.
    push(1, 1, 0, 0); push(1, 1, 0, 2); push(3, 1, 0, 0); push(3, 1, 0, 2);
    drive();
    run_expect("rrwrap", 1, '{1, 1, 3, 3}, 0);

    // Wormhole: West owns Local for 4 flits, East's head waits.
    push(3, 4, 2, 0); push(3, 4, 2, 1); push(3, 4, 2, 1); push(3, 4, 2, 2);
    drive();
    run_expect("wh0", 4, '{3}, 2);
    chk("wh_locked", 32'(out_locked[4]), 32'h1);
    push(1, 4, 3, 0); push(1, 4, 3, 2);
    drive();
    run_expect("wh1", 4, '{3, 3, 3}, 2);
    run_expect("wh2", 4, '{1, 1, 7}, 3);
    chk("wh_unlocked", 32'(out_locked[4]), 32'h0);

    // Backpressure on South mid-packet.
    push(0, 2, 2, 0); push(0, 2, 2, 1); push(0, 2, 2, 1); push(0, 2, 2, 2);
    push(4, 2, 2, 0); push(4, 2, 2, 2);
    drive();
    run_expect("bp0", 2, '{0}, 2);
    out_ready[2] = 1'b0;
    run_expect("bp1", 2, '{7, 7, 7}, 2);
    chk("bp_locked", 32'(out_locked[2]), 32'h1);
    out_ready[2] = 1'b1;
    run_expect("bp2", 2, '{0, 0, 0, 4, 4}, 2);

    // Illegal requests never granted.
    push(0, 5, 0, 0); push(1, 0, 0, 3); push(2, 3, 0, 1);
    drive();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("ill_grant%0d", c), 32'(in_grant), 32'h0);
      chk($sformatf("ill_locked%0d", c), 32'(out_locked), 32'h0);
      finish_cycle();
    end
    for (int i = 0; i < NP; i++) q[i].delete();
    drive();

`ifdef SA_LOCK_TIMEOUT_EN
    // Owner of North goes silent after its head; lock expires after LT idle cycles.
    push(1, 0, 0, 0);
    drive();
    run_expect("to0", 0, '{1}, 0);
    push(2, 0, 1, 0); push(2, 0, 1, 2);
    drive();
    run_expect("to1", 0, '{7, 7, 7, 7}, 0);
    @(negedge clk);
    chk("to_pulse", 32'(lock_timeout), 32'h1);
    chk("to_unlocked", 32'(out_locked[0]), 32'h0);
    chk("to_newwin", 32'(xbar_sel[2:0]), 32'h2);
    finish_cycle();
    run_expect("to2", 0, '{2, 7}, 1);
    chk("to_pulse_gone", 32'(lock_timeout), 32'h0);
`endif

    repeat (2) begin @(negedge clk); finish_cycle(); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
